// File: rtl/sequenciador_soma_sub_pkg.sv
// rtl/sequenciador_soma_sub_pkg.sv - shared opcodes, state codes and sizing helper
package sequenciador_soma_sub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Nibble index width; a single-nibble build still needs one bit.
  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/sequenciador_soma_sub_if.sv
// rtl/sequenciador_soma_sub_if.sv - request/response bus of the add/sub sequencer
interface sequenciador_soma_sub_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout_bout;
  logic         zero;
  logic         overflow;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, cout_bout, zero, overflow
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, cout_bout, zero, overflow
  );

endinterface

// File: rtl/sequenciador_soma_sub_adder.sv
// rtl/sequenciador_soma_sub_adder.sv - 4-bit ripple-carry adder shared across nibbles
module adder (
  output logic [3:0] S,
  output logic       Cout,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin
);

  logic [4:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign Cout = c[4];

endmodule

// File: rtl/sequenciador_soma_sub.sv
// rtl/sequenciador_soma_sub.sv - multi-precision add/sub, one nibble per cycle on a shared adder
module sequenciador_soma_sub
  import sequenciador_soma_sub_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sequenciador_soma_sub_if.slave bus
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = idx_width(NIBBLES);

  state_t            state_q;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic [W-1:0]      result_q;
  logic [IDXW-1:0]   idx_q;
  logic              op_q;
  logic              carry_q;
  logic              cout_bout_q;
  logic              zero_q;
  logic              overflow_q;

  logic [3:0]        a_nib;
  logic [3:0]        b_nib;
  logic [3:0]        sum;
  logic              sum_cout;
  logic [W-1:0]      result_d;
  logic              overflow_d;
  logic              last_nib;

  // Subtraction is A + ~B + 1: the +1 comes from carry_q being seeded with op.
  assign a_nib = 4'(a_q >> {idx_q, 2'b00});
  assign b_nib = op_q ? ~4'(b_q >> {idx_q, 2'b00}) : 4'(b_q >> {idx_q, 2'b00});

  adder u_adder (
    .S    (sum),
    .Cout (sum_cout),
    .A    (a_nib),
    .B    (b_nib),
    .Cin  (carry_q)
  );

  always_comb begin
    result_d = result_q;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDXW'(i)) begin
        result_d[i*4 +: 4] = sum;
      end
    end
  end

  assign last_nib   = (idx_q == IDXW'(NIBBLES - 1));
  assign overflow_d = (op_q == OP_SUB)
                    ? ((a_q[W-1] != b_q[W-1]) && (result_d[W-1] != a_q[W-1]))
                    : ((a_q[W-1] == b_q[W-1]) && (result_d[W-1] != a_q[W-1]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      idx_q       <= '0;
      op_q        <= OP_ADD;
      carry_q     <= 1'b0;
      cout_bout_q <= 1'b0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            op_q     <= bus.op;
            carry_q  <= bus.op;
            idx_q    <= '0;
            result_q <= '0;
            state_q  <= ST_CALC;
          end
        end
        ST_CALC: begin
          result_q <= result_d;
          carry_q  <= sum_cout;
          if (last_nib) begin
            cout_bout_q <= (op_q == OP_SUB) ? ~sum_cout : sum_cout;
            zero_q      <= ~|result_d;
            overflow_q  <= overflow_d;
            idx_q       <= '0;
            state_q     <= ST_DONE;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.cout_bout = cout_bout_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = overflow_q;

endmodule
